// File: rtl/ram_scan_reader.sv
// ram_scan_reader
// ---------------------------------------------------------------------------
// Read-side controller for the single-port display RAM. Walks the inclusive
// address range [first_addr .. last_addr] (wrapping through 0 when
// first_addr > last_addr), issues one read per address, waits out the RAM
// read latency, then presents each {address, data} pair to the display
// driver on a valid/ready port. This block never writes the RAM.
//
// Parameters
//   AW      address width (RAM depth 2**AW)
//   DW      data width
//   RD_LAT  RAM read latency in clocks, 0..7 (0 = combinational mem_dout)
//
// Ports
//   clk         system clock
//   reset_n     synchronous, active-low reset
//   start       begin a scan; only looked at while idle
//   abort       stop the scan at once; beats every other input except reset
//   loop        1 = restart at first_addr after last_addr (sampled at wrap)
//   first_addr  first address of the range, latched when start is accepted
//   last_addr   last address of the range, latched when start is accepted
//   mem_addr    registered RAM read address
//   mem_dout    RAM read data
//   out_valid   out_addr/out_data hold a captured word
//   out_ready   consumer ready
//   out_addr    address of the presented word
//   out_data    presented word
//   busy        1 whenever a scan is in progress
//   done        one-cycle pulse after the last word of a non-looping scan
//   dbg_state   current FSM state (0 idle, 1 wait, 2 hold)
//
// Output handshake: a word transfers on a rising clk edge where out_valid
// and out_ready are both 1. Once out_valid is 1, out_addr and out_data stay
// constant until that transfer edge (or abort / reset). out_valid never
// depends combinationally on out_ready.
// ---------------------------------------------------------------------------
module ram_scan_reader #(
    parameter int AW     = 8,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic          loop,
    input  logic [AW-1:0] first_addr,
    input  logic [AW-1:0] last_addr,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_dout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic          done,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Wait counter reload value. The WAIT state lasts RD_LAT+1 cycles: the
    // counter starts at RD_LAT and the capture happens on the edge where it
    // reads zero.
    localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

    state_t        state_q, state_d;
    logic [AW-1:0] cur_q, cur_d;
    logic [AW-1:0] first_q, first_d;
    logic [AW-1:0] last_q, last_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [AW-1:0] out_addr_q, out_addr_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          done_q, done_d;
    logic [AW-1:0] cur_inc;

    // Natural AW-bit wrap gives the 255 -> 0 step for ranges crossing zero.
    assign cur_inc = cur_q + AW'(1);

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cur_q       <= '0;
            first_q     <= '0;
            last_q      <= '0;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            first_q     <= first_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and next-datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        first_d     = first_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;     // done is a single-cycle pulse

        if (abort) begin
            // Abort drops the presented word but leaves the address and data
            // registers alone so the display keeps showing the last word.
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        first_d    = first_addr;
                        last_d     = last_addr;
                        cur_d      = first_addr;
                        mem_addr_d = first_addr;
                        cnt_d      = LAT_INIT;
                        state_d    = S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (cnt_q == 3'd0) begin
                        out_data_d  = mem_dout;
                        out_addr_d  = cur_q;
                        out_valid_d = 1'b1;
                        state_d     = S_HOLD;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end

                S_HOLD: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        if (cur_q != last_q) begin
                            cur_d      = cur_inc;
                            mem_addr_d = cur_inc;
                            cnt_d      = LAT_INIT;
                            state_d    = S_WAIT;
                        end else if (loop) begin
                            cur_d      = first_q;
                            mem_addr_d = first_q;
                            cnt_d      = LAT_INIT;
                            state_d    = S_WAIT;
                        end else begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end

                default: begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    assign mem_addr  = mem_addr_q;
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_scan_reader.sv
// Bench for ram_scan_reader. Three instances with RD_LAT = 1, 0, 3 share
// reset and a common RAM image; each instance has its own latency pipeline.
// Expected {addr, data} words are computed from the address range and pushed
// into a per-instance queue; a negedge monitor pops and compares on every
// handshake.
module tb_ram_scan_reader;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int N  = 3;
    localparam int EW = AW + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic          start      [N];
    logic          abort      [N];
    logic          loop_r     [N];
    logic          out_ready  [N];
    logic [AW-1:0] first_addr [N];
    logic [AW-1:0] last_addr  [N];
    logic [AW-1:0] mem_addr   [N];
    logic [AW-1:0] out_addr   [N];
    logic [DW-1:0] mem_dout   [N];
    logic [DW-1:0] out_data   [N];
    logic          out_valid  [N];
    logic          busy       [N];
    logic          done       [N];
    logic [1:0]    dbg_state  [N];

    logic [DW-1:0] ram [256];

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int L  = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        localparam int PI = (L == 0) ? 0 : L - 1;
        logic [DW-1:0] pipe [8];

        // RAM read model: data for an address appears L edges later.
        always @(posedge clk) begin
            pipe[0] <= ram[mem_addr[g]];
            for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
        end
        assign mem_dout[g] = (L == 0) ? ram[mem_addr[g]] : pipe[PI];

        ram_scan_reader #(.AW(AW), .DW(DW), .RD_LAT(L)) u_dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .start      (start[g]),
            .abort      (abort[g]),
            .loop       (loop_r[g]),
            .first_addr (first_addr[g]),
            .last_addr  (last_addr[g]),
            .mem_addr   (mem_addr[g]),
            .mem_dout   (mem_dout[g]),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready[g]),
            .out_addr   (out_addr[g]),
            .out_data   (out_data[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .dbg_state  (dbg_state[g])
        );
    end

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    logic [EW-1:0] exp_q2[$];
    int hs_cyc[$];
    int done_cnt [N];
    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic void push_exp(input int k, input logic [EW-1:0] v);
        case (k)
            0: exp_q0.push_back(v);
            1: exp_q1.push_back(v);
            default: exp_q2.push_back(v);
        endcase
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0: return exp_q0.size();
            1: return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    function automatic logic [EW-1:0] qfront(input int k);
        case (k)
            0: return exp_q0[0];
            1: return exp_q1[0];
            default: return exp_q2[0];
        endcase
    endfunction

    function automatic logic [EW-1:0] qpop(input int k);
        case (k)
            0: return exp_q0.pop_front();
            1: return exp_q1.pop_front();
            default: return exp_q2.pop_front();
        endcase
    endfunction

    // Monitor: a handshake seen at negedge completes on the next posedge.
    always @(negedge clk) begin : mon
        logic [EW-1:0] exp_v;
        for (int k = 0; k < N; k++) begin
            if (reset_n && out_valid[k] && out_ready[k] && !abort[k]) begin
                if (qsize(k) == 0) begin
                    check("unexpected_word", {40'd0, out_addr[k], out_data[k]}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_v = qpop(k);
                    check("word", {40'd0, out_addr[k], out_data[k]}, {40'd0, exp_v});
                end
                if (k == 0) hs_cyc.push_back(cyc);
            end
            if (done[k]) done_cnt[k]++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start a scan on instance k; optionally push the expected words and
    // measure start-to-valid latency.
    task automatic start_scan(input int k, input logic [AW-1:0] f, input logic [AW-1:0] l,
                              input bit push, input bit chk_lat);
        logic [AW-1:0] span;
        logic [AW-1:0] a;
        int edges;
        span = l - f;
        if (push) begin
            for (int i = 0; i <= int'(span); i++) begin
                a = f + AW'(i);
                push_exp(k, {a, ram[a]});
            end
        end
        first_addr[k] = f;
        last_addr[k]  = l;
        start[k]      = 1'b1;
        tick(1);
        start[k]      = 1'b0;
        check("start_busy", {63'd0, busy[k]}, 64'd1);
        check("start_mem_addr", {56'd0, mem_addr[k]}, {56'd0, f});
        if (chk_lat) begin
            edges = 0;
            while (!out_valid[k] && edges < 64) begin
                tick(1);
                edges++;
            end
            check("latency", 64'(edges), 64'(lat_of(k) + 1));
        end
    endtask

    task automatic wait_valid(input int k);
        int n;
        n = 0;
        while (!out_valid[k] && n < 100) begin
            tick(1);
            n++;
        end
        check("wait_valid_timeout", {63'd0, out_valid[k]}, 64'd1);
    endtask

    task automatic wait_idle(input int k, input int budget, input bit rnd_ready);
        int n;
        n = 0;
        while (busy[k] && n < budget) begin
            if (rnd_ready) out_ready[k] = 1'($urandom_range(0, 1));
            tick(1);
            n++;
        end
        out_ready[k] = 1'b1;
        check("idle_timeout", {63'd0, busy[k]}, 64'd0);
        tick(1);    // let the monitor see the done pulse
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        n_fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        int d;
        int n;
        logic [AW-1:0] f;
        logic [AW-1:0] l;

        reset_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            start[k] = 1'b0; abort[k] = 1'b0; loop_r[k] = 1'b0; out_ready[k] = 1'b1;
            first_addr[k] = '0; last_addr[k] = '0; done_cnt[k] = 0;
        end
        for (int i = 0; i < 256; i++) ram[i] = 16'(i * 3);
        tick(3);

        // Reset values
        for (int k = 0; k < N; k++) begin
            check("rst_valid", {63'd0, out_valid[k]}, 64'd0);
            check("rst_busy", {63'd0, busy[k]}, 64'd0);
            check("rst_done", {63'd0, done[k]}, 64'd0);
            check("rst_mem_addr", {56'd0, mem_addr[k]}, 64'd0);
            check("rst_out_addr", {56'd0, out_addr[k]}, 64'd0);
            check("rst_out_data", {48'd0, out_data[k]}, 64'd0);
        end
        reset_n = 1'b1;
        tick(1);

        // Basic scan 2..5, ready held high: 4 words, one per RD_LAT+2 cycles
        hs_cyc.delete();
        d = done_cnt[0];
        start_scan(0, 8'h02, 8'h05, 1'b1, 1'b1);
        wait_idle(0, 200, 1'b0);
        check("t1_done", 64'(done_cnt[0] - d), 64'd1);
        check("t1_busy", {63'd0, busy[0]}, 64'd0);
        check("t1_q_empty", 64'(qsize(0)), 64'd0);
        check("t1_hs_count", 64'(hs_cyc.size()), 64'd4);
        for (int i = 1; i < hs_cyc.size(); i++)
            check("t1_gap", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'(lat_of(0) + 2));

        // Range wrapping through zero
        d = done_cnt[0];
        start_scan(0, 8'hFE, 8'h01, 1'b1, 1'b1);
        wait_idle(0, 200, 1'b0);
        check("t2_done", 64'(done_cnt[0] - d), 64'd1);
        check("t2_q_empty", 64'(qsize(0)), 64'd0);

        // Backpressure: presented word must stay put while ready is low
        out_ready[0] = 1'b0;
        d = done_cnt[0];
        start_scan(0, 8'h20, 8'h23, 1'b1, 1'b0);
        wait_valid(0);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("t3_hold_valid", {63'd0, out_valid[0]}, 64'd1);
            check("t3_hold_word", {40'd0, out_addr[0], out_data[0]}, {40'd0, qfront(0)});
        end
        out_ready[0] = 1'b1;
        wait_idle(0, 200, 1'b0);
        check("t3_done", 64'(done_cnt[0] - d), 64'd1);
        check("t3_q_empty", 64'(qsize(0)), 64'd0);

        // Loop on a single address, then drop loop
        d = done_cnt[0];
        loop_r[0] = 1'b1;
        for (int i = 0; i < 5; i++) push_exp(0, {8'h10, ram[8'h10]});
        start_scan(0, 8'h10, 8'h10, 1'b0, 1'b0);
        n = 0;
        while (qsize(0) != 0 && n < 200) begin
            tick(1);
            n++;
        end
        check("t4_loop_drain", 64'(qsize(0)), 64'd0);
        check("t4_no_done", 64'(done_cnt[0] - d), 64'd0);
        check("t4_still_busy", {63'd0, busy[0]}, 64'd1);
        loop_r[0] = 1'b0;
        push_exp(0, {8'h10, ram[8'h10]});
        wait_idle(0, 200, 1'b0);
        check("t4_done", 64'(done_cnt[0] - d), 64'd1);
        check("t4_q_empty", 64'(qsize(0)), 64'd0);

        // Abort while waiting for the RAM
        d = done_cnt[0];
        start_scan(0, 8'h30, 8'h35, 1'b0, 1'b0);
        abort[0] = 1'b1;
        tick(1);
        abort[0] = 1'b0;
        check("t5w_valid", {63'd0, out_valid[0]}, 64'd0);
        check("t5w_busy", {63'd0, busy[0]}, 64'd0);
        start_scan(0, 8'h40, 8'h41, 1'b1, 1'b1);
        wait_idle(0, 200, 1'b0);
        check("t5w_done", 64'(done_cnt[0] - d), 64'd1);

        // Abort while holding a word
        out_ready[0] = 1'b0;
        d = done_cnt[0];
        start_scan(0, 8'h50, 8'h55, 1'b0, 1'b0);
        wait_valid(0);
        abort[0] = 1'b1;
        tick(1);
        abort[0] = 1'b0;
        check("t5h_valid", {63'd0, out_valid[0]}, 64'd0);
        check("t5h_busy", {63'd0, busy[0]}, 64'd0);
        check("t5h_out_addr", {56'd0, out_addr[0]}, 64'h50);
        check("t5h_out_data", {48'd0, out_data[0]}, {48'd0, ram[8'h50]});
        check("t5h_mem_addr", {56'd0, mem_addr[0]}, 64'h50);
        out_ready[0] = 1'b1;
        start_scan(0, 8'h58, 8'h58, 1'b1, 1'b1);
        wait_idle(0, 200, 1'b0);
        check("t5h_done", 64'(done_cnt[0] - d), 64'd1);

        // start together with abort in idle: abort wins
        abort[0] = 1'b1;
        start[0] = 1'b1;
        tick(1);
        abort[0] = 1'b0;
        start[0] = 1'b0;
        check("t5i_busy", {63'd0, busy[0]}, 64'd0);

        // Reset in the middle of a scan
        out_ready[0] = 1'b0;
        d = done_cnt[0];
        start_scan(0, 8'h60, 8'h62, 1'b0, 1'b0);
        wait_valid(0);
        reset_n = 1'b0;
        tick(1);
        check("t6_valid", {63'd0, out_valid[0]}, 64'd0);
        check("t6_busy", {63'd0, busy[0]}, 64'd0);
        check("t6_mem_addr", {56'd0, mem_addr[0]}, 64'd0);
        check("t6_out_addr", {56'd0, out_addr[0]}, 64'd0);
        check("t6_out_data", {48'd0, out_data[0]}, 64'd0);
        reset_n = 1'b1;
        out_ready[0] = 1'b1;
        tick(1);
        check("t6_no_done", 64'(done_cnt[0] - d), 64'd0);

        // Latency sweep on the RD_LAT=0 and RD_LAT=3 instances
        for (int k = 1; k < N; k++) begin
            d = done_cnt[k];
            start_scan(k, 8'h70, 8'h73, 1'b1, 1'b1);
            wait_idle(k, 200, 1'b0);
            check("lat_done", 64'(done_cnt[k] - d), 64'd1);
            check("lat_q_empty", 64'(qsize(k)), 64'd0);
        end

        // Random RAM contents, ranges and consumer backpressure
        for (int it = 0; it < 9; it++) begin
            int k;
            k = it % N;
            for (int i = 0; i < 256; i++) ram[i] = 16'($urandom);
            tick(4);    // let the latency pipelines settle on the new image
            f = 8'($urandom_range(0, 255));
            l = f + 8'($urandom_range(0, 9));
            d = done_cnt[k];
            start_scan(k, f, l, 1'b1, 1'b0);
            wait_idle(k, 2000, 1'b1);
            check("rnd_done", 64'(done_cnt[k] - d), 64'd1);
            check("rnd_q_empty", 64'(qsize(k)), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
